// File: rtl/output_bram_axis_reader.sv
// Streams a finished output frame from port B of the output BRAM onto an
// AXI4-Stream master, using a 2-entry skid FIFO to absorb tready back-pressure.
module output_bram_axis_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] frame_len,
  output logic                  busy,
  output logic                  done,
  output logic                  enb_output_BRAM,
  output logic [ADDR_WIDTH-1:0] addrb_output_BRAM,
  input  logic [DATA_WIDTH-1:0] doutb_output_BRAM,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  typedef enum logic [1:0] {S_Idle, S_Stream, S_Drain, S_Done} state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   len_r;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [ADDR_WIDTH-1:0]   beat_cnt;
  logic [ADDR_WIDTH-1:0]   addr_hold;
  logic                    rd_vld_p0;
  logic                    rd_last_p0;
  logic [DATA_WIDTH-1:0]   fifo_data [2];
  logic [1:0]              fifo_last;
  logic                    wr_ptr, rd_ptr;
  logic [1:0]              fifo_cnt;
  logic [2:0]              occ;
  logic                    push, pop, issue, is_last_addr, is_last_beat;

  assign push         = rd_vld_p0;
  assign pop          = (fifo_cnt != 2'd0) && m_axis_tready;
  assign occ          = {1'b0, fifo_cnt} + {2'b00, rd_vld_p0};
  assign is_last_addr = (rd_addr == (len_r - ONE));
  assign is_last_beat = (beat_cnt == (len_r - ONE));
  // Credit check counts the pop of this cycle so reads resume without a bubble.
  assign issue        = (state == S_Stream) && (occ < (3'd2 + {2'b00, pop}));

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_Idle:   if (start) state_nxt = (frame_len != '0) ? S_Stream : S_Done;
      S_Stream: if (issue && is_last_addr) state_nxt = S_Drain;
      S_Drain:  if (pop && is_last_beat) state_nxt = S_Done;
      S_Done:   state_nxt = S_Idle;
      default:  state_nxt = S_Idle;
    endcase
  end

  // Read-issue stage: control state, counters and the in-flight marker.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state      <= S_Idle;
      len_r      <= '0;
      rd_addr    <= '0;
      beat_cnt   <= '0;
      addr_hold  <= '0;
      rd_vld_p0  <= 1'b0;
      rd_last_p0 <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_cnt   <= 2'd0;
    end else begin
      state      <= state_nxt;
      rd_vld_p0  <= issue;
      rd_last_p0 <= issue && is_last_addr;
      if (state == S_Idle && start && frame_len != '0) begin
        len_r    <= frame_len;
        rd_addr  <= '0;
        beat_cnt <= '0;
      end
      if (issue) begin
        rd_addr   <= rd_addr + ONE;
        addr_hold <= rd_addr;
      end
      if (pop) begin
        beat_cnt <= beat_cnt + ONE;
        rd_ptr   <= ~rd_ptr;
      end
      if (push) wr_ptr <= ~wr_ptr;
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Capture stage: BRAM data lands in the FIFO the cycle it becomes valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= doutb_output_BRAM;
      fifo_last[wr_ptr] <= rd_last_p0;
    end
  end

  assign busy              = (state == S_Stream) || (state == S_Drain);
  assign done              = (state == S_Done);
  assign enb_output_BRAM   = issue;
  assign addrb_output_BRAM = issue ? rd_addr : addr_hold;
  assign m_axis_tvalid     = (fifo_cnt != 2'd0);
  // Gating by tvalid keeps the unreset data registers invisible after reset.
  assign m_axis_tdata      = m_axis_tvalid ? fifo_data[rd_ptr] : '0;
  assign m_axis_tlast      = m_axis_tvalid && fifo_last[rd_ptr];

endmodule

// File: tb/tb_output_bram_axis_reader.sv
// Bench for output_bram_axis_reader: BRAM model, frame-level stream model and
// per-cycle compare process, driven by directed frames.
module tb_output_bram_axis_reader;

  localparam int DW = 16;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          Reset;
  logic          start;
  logic [AW-1:0] frame_len;
  logic          busy, done, enb;
  logic [AW-1:0] addrb;
  logic [DW-1:0] doutb;
  logic [DW-1:0] tdata;
  logic          tvalid, tready, tlast;

  output_bram_axis_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .Reset(Reset), .start(start), .frame_len(frame_len),
    .busy(busy), .done(done), .enb_output_BRAM(enb),
    .addrb_output_BRAM(addrb), .doutb_output_BRAM(doutb),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tlast(tlast)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word_of(input int a);
    return 16'hC000 + DW'(a * 7);
  endfunction

  // Synchronous-read BRAM: data valid one cycle after the enabled read.
  always @(posedge clk) if (enb) doutb <= word_of(int'(addrb));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame model state
  bit            mon_on = 0, frame_on = 0, m_finished = 0;
  int            m_len, m_start, m_beat, m_issued, m_hs_cyc;
  int            first_valid_cyc, done_cyc, n_tlast, pend;
  logic [DW-1:0] first_data, last_data;
  bit            first_last;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data;
  bit            prev_last;
  bit            hs;

  always @(negedge clk) begin
    if (mon_on) begin
      hs = tvalid && tready;
      chk("busy", int'(busy), int'(frame_on && !m_finished && cyc > m_start));
      chk("done", int'(done), int'(frame_on && m_finished && cyc == m_hs_cyc + 1));
      if (done) done_cyc = cyc;
      if (prev_stall) begin
        chk("hold_tvalid", int'(tvalid), 1);
        chk("hold_tdata", int'(tdata), int'(prev_data));
        chk("hold_tlast", int'(tlast), int'(prev_last));
      end
      if (!frame_on || m_finished) begin
        chk("idle_tvalid", int'(tvalid), 0);
        chk("idle_enb", int'(enb), 0);
      end else begin
        if (enb) begin
          chk("rd_addr", int'(addrb), m_issued);
          chk("rd_in_range", int'(m_issued < m_len), 1);
          pend = m_issued + 1 - m_beat - int'(hs);
          chk("outstanding_le2", int'(pend <= 2), 1);
          m_issued++;
        end
        if (hs) begin
          chk("beat_data", int'(tdata), int'(word_of(m_beat)));
          chk("beat_last", int'(tlast), int'(m_beat == m_len - 1));
          if (m_beat == 0) begin
            first_valid_cyc = cyc;
            first_data = tdata;
            first_last = tlast;
          end
          last_data = tdata;
          if (tlast) n_tlast++;
          m_beat++;
          if (m_beat == m_len) begin
            m_finished = 1;
            m_hs_cyc = cyc;
          end
        end
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  task automatic start_frame(input int len);
    @(posedge clk); #1;
    start = 1'b1;
    frame_len = AW'(len);
    m_len = len; m_start = cyc; m_beat = 0; m_issued = 0;
    m_finished = (len == 0); m_hs_cyc = cyc;
    first_valid_cyc = -1; done_cyc = -1; n_tlast = 0;
    frame_on = 1;
    @(posedge clk); #1;
    start = 1'b0;
    frame_len = AW'(15'h1234);
  endtask

  // mode 0: tready=1; 1: pattern 1,0,0,1,0,1; 2: tready=0 until rel cycle 53.
  // inj >= 0 pulses a stray start with another frame_len at that rel cycle.
  task automatic run_frame(input int mode, input int inj);
    bit pat [6] = '{1, 0, 0, 1, 0, 1};
    int rel;
    for (int i = 0; i < 300 && done_cyc < 0; i++) begin
      rel = cyc - m_start;
      case (mode)
        1:       tready = pat[rel % 6];
        2:       tready = (rel >= 53);
        default: tready = 1'b1;
      endcase
      if (rel == inj) begin start = 1'b1; frame_len = AW'(3); end
      else start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    tready = 1'b1;
    if (done_cyc < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout: no done, beats %0d of %0d", m_beat, m_len);
    end
    chk("beats_total", m_beat, m_len);
    frame_on = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_done"},  int'(done), 0);
    chk({tag, "_enb"},   int'(enb), 0);
    chk({tag, "_addrb"}, int'(addrb), 0);
    chk({tag, "_tvalid"}, int'(tvalid), 0);
    chk({tag, "_tlast"}, int'(tlast), 0);
    chk({tag, "_tdata"}, int'(tdata), 0);
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; frame_len = '0; tready = 1'b1;
    repeat (2) @(posedge clk);
    #1 Reset = 1'b0;
    chk_reset_outputs("rst");
    mon_on = 1;

    // Full rate, 16 words
    start_frame(16);
    run_frame(0, -1);
    chk("fr_first_valid_rel", first_valid_cyc - m_start, 3);
    chk("fr_last_beat_rel", m_hs_cyc - m_start, 18);
    chk("fr_done_rel", done_cyc - m_start, 19);
    chk("fr_word0", int'(first_data), 16'hC000);
    chk("fr_word15", int'(last_data), 16'hC069);
    chk("fr_tlast_count", n_tlast, 1);

    // Back-pressure pattern, 8 words
    start_frame(8);
    run_frame(1, -1);
    chk("bp_word7", int'(last_data), 16'hC031);
    chk("bp_tlast_count", n_tlast, 1);

    // Single-word frame
    start_frame(1);
    run_frame(0, -1);
    chk("len1_first_tlast", int'(first_last), 1);
    chk("len1_done_after_hs", done_cyc - m_hs_cyc, 1);
    chk("len1_done_rel", done_cyc - m_start, 4);

    // Empty frame
    start_frame(0);
    run_frame(0, -1);
    chk("len0_done_rel", done_cyc - m_start, 1);
    chk("len0_reads", m_issued, 0);
    chk("len0_no_beat", first_valid_cyc, -1);

    // Reset at beat 10 of a 32-word frame
    start_frame(32);
    for (int i = 0; i < 100 && m_beat < 10; i++) begin
      @(posedge clk); #1;
    end
    chk("mid_reached_beat10", m_beat, 10);
    mon_on = 0;
    Reset = 1'b1;
    @(posedge clk); #1;
    Reset = 1'b0;
    frame_on = 0; prev_stall = 0;
    chk_reset_outputs("midrst");
    mon_on = 1;
    repeat (5) @(posedge clk);
    start_frame(4);
    run_frame(0, -1);
    chk("after_rst_word3", int'(last_data), 16'hC015);
    chk("after_rst_done_rel", done_cyc - m_start, 7);

    // Stray start with another frame_len while streaming 12 words
    start_frame(12);
    run_frame(0, 5);
    chk("ign_done_rel", done_cyc - m_start, 15);
    chk("ign_word11", int'(last_data), 16'hC04D);

    // tready low for 50 cycles from the first valid beat
    start_frame(12);
    run_frame(2, -1);
    chk("stall_first_beat_rel", first_valid_cyc - m_start, 53);
    chk("stall_word0", int'(first_data), 16'hC000);
    chk("stall_done_rel", done_cyc - m_start, 65);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
